// File: rtl/cache_lookup_ctrl.sv
// Lookup/replacement controller in front of a 4-way MOESI tag array.
// Classifies each request as hit, miss or upgrade, picks a victim on miss and rewrites LRU/state per way.
module cache_lookup_ctrl #(
  parameter int unsigned SETS       = 128,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = ADDR_WIDTH - $clog2(SETS) - 6,
  parameter int unsigned LRU_BITS   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic                          req_write,
  output logic [$clog2(SETS)-1:0]       tag_rd_set,
  input  logic [WAYS*TAG_WIDTH-1:0]     tag_rd_tags,
  input  logic [WAYS-1:0]               tag_rd_valids,
  input  logic [WAYS*3-1:0]             tag_rd_states,
  input  logic [WAYS*LRU_BITS-1:0]      tag_rd_lru,
  output logic                          tag_wr_en,
  output logic [$clog2(SETS)-1:0]       tag_wr_set,
  output logic [$clog2(WAYS)-1:0]       tag_wr_way,
  output logic [TAG_WIDTH-1:0]          tag_wr_tag,
  output logic                          tag_wr_valid,
  output logic [2:0]                    tag_wr_state,
  output logic [LRU_BITS-1:0]           tag_wr_lru,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [1:0]                    resp_kind,
  output logic [$clog2(WAYS)-1:0]       resp_way,
  output logic [2:0]                    resp_state,
  output logic [TAG_WIDTH-1:0]          resp_victim_tag,
  output logic                          resp_victim_dirty
);
  localparam int unsigned SETW = $clog2(SETS);
  localparam int unsigned WAYW = $clog2(WAYS);
  localparam logic [LRU_BITS-1:0] LRU_MAX = LRU_BITS'(WAYS - 1);
  localparam logic [2:0] ST_I = 3'b000, ST_M = 3'b001, ST_O = 3'b010, ST_E = 3'b100, ST_S = 3'b101;
  localparam logic [1:0] K_HIT = 2'b00, K_MISS = 2'b01, K_UPG = 2'b10;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;

  state_t                r_state, w_next;
  logic [SETW-1:0]       r_set;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_write;
  logic [TAG_WIDTH-1:0]  r_tags   [WAYS];
  logic [2:0]            r_states [WAYS];
  logic [LRU_BITS-1:0]   r_lru    [WAYS];
  logic [WAYS-1:0]       r_valids;
  logic [WAYW-1:0]       r_way, r_cnt;
  logic [1:0]            r_kind;

  logic [TAG_WIDTH-1:0]  w_rd_tag   [WAYS];
  logic [2:0]            w_rd_state [WAYS];
  logic [LRU_BITS-1:0]   w_rd_lru   [WAYS];
  logic                  w_hit, w_inv_found;
  logic [WAYW-1:0]       w_hit_way, w_inv_way, w_max_way, w_victim;
  logic [LRU_BITS-1:0]   w_max_age, w_h_age, w_cur_age, w_wr_lru;
  logic [2:0]            w_hit_state, w_wr_state;
  logic [1:0]            w_kind;
  logic                  w_unused_offset;

  assign w_unused_offset = ^req_addr[5:0];

  // Hit: lowest matching valid way. Victim: lowest free way, else oldest (lowest index on ties).
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_max_way   = '0;
    w_max_age   = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      w_rd_tag[i]   = tag_rd_tags[i*TAG_WIDTH +: TAG_WIDTH];
      w_rd_state[i] = tag_rd_states[i*3 +: 3];
      w_rd_lru[i]   = tag_rd_lru[i*LRU_BITS +: LRU_BITS];
    end
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!w_hit && tag_rd_valids[i] && w_rd_state[i] != ST_I && w_rd_tag[i] == r_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAYW'(i);
      end
      if (!w_inv_found && (!tag_rd_valids[i] || w_rd_state[i] == ST_I)) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAYW'(i);
      end
      if (w_rd_lru[i] > w_max_age) begin
        w_max_age = w_rd_lru[i];
        w_max_way = WAYW'(i);
      end
    end
    w_victim    = w_inv_found ? w_inv_way : w_max_way;
    w_hit_state = w_rd_state[w_hit_way];
    if (!w_hit)
      w_kind = K_MISS;
    else if (r_write && (w_hit_state == ST_S || w_hit_state == ST_O))
      w_kind = K_UPG;
    else
      w_kind = K_HIT;
  end

  always_comb begin
    w_h_age   = r_lru[r_way];
    w_cur_age = r_lru[r_cnt];
    if (r_cnt == r_way)
      w_wr_lru = '0;
    else if (w_cur_age < w_h_age)
      w_wr_lru = (w_cur_age == LRU_MAX) ? w_cur_age : w_cur_age + LRU_BITS'(1);
    else
      w_wr_lru = w_cur_age;
    if (r_cnt == r_way && r_write && r_states[r_cnt] == ST_E)
      w_wr_state = ST_M;
    else
      w_wr_state = r_states[r_cnt];
  end

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    tag_wr_en    = 1'b0;
    tag_wr_set   = '0;
    tag_wr_way   = '0;
    tag_wr_tag   = '0;
    tag_wr_valid = 1'b0;
    tag_wr_state = '0;
    tag_wr_lru   = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = LOOKUP;
      end
      LOOKUP: w_next = w_hit ? UPDATE : RESP;
      UPDATE: begin
        tag_wr_en    = 1'b1;
        tag_wr_set   = r_set;
        tag_wr_way   = r_cnt;
        tag_wr_tag   = r_tags[r_cnt];
        tag_wr_valid = r_valids[r_cnt];
        tag_wr_state = w_wr_state;
        tag_wr_lru   = w_wr_lru;
        if (r_cnt == WAYW'(WAYS - 1)) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_set    <= '0;
      r_tag    <= '0;
      r_write  <= 1'b0;
      r_valids <= '0;
      r_way    <= '0;
      r_cnt    <= '0;
      r_kind   <= '0;
      for (int unsigned i = 0; i < WAYS; i++) begin
        r_tags[i]   <= '0;
        r_states[i] <= '0;
        r_lru[i]    <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_set   <= req_addr[6 +: SETW];
          r_tag   <= req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
          r_write <= req_write;
        end
        LOOKUP: begin
          r_valids <= tag_rd_valids;
          for (int unsigned i = 0; i < WAYS; i++) begin
            r_tags[i]   <= w_rd_tag[i];
            r_states[i] <= w_rd_state[i];
            r_lru[i]    <= w_rd_lru[i];
          end
          r_way  <= w_hit ? w_hit_way : w_victim;
          r_kind <= w_kind;
          r_cnt  <= '0;
        end
        UPDATE: r_cnt <= r_cnt + WAYW'(1);
        default: ;
      endcase
    end
  end

  assign tag_rd_set        = r_set;
  assign resp_kind         = r_kind;
  assign resp_way          = r_way;
  assign resp_state        = r_states[r_way];
  assign resp_victim_tag   = r_tags[r_way];
  assign resp_victim_dirty = (r_kind == K_MISS) && (resp_state == ST_M || resp_state == ST_O);

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Directed bench for cache_lookup_ctrl: table of preload/request/expected-result records
// against a one-set tag array model, plus handshake-hold and mid-update reset sequences.
module tb_cache_lookup_ctrl;
  localparam logic [2:0] SI = 3'b000, SM = 3'b001, SO = 3'b010, SE = 3'b100, SS = 3'b101;
  localparam logic [75:0] DT = {19'd8, 19'd7, 19'd6, 19'd5};
  localparam logic [11:0] DS = {SO, SM, SS, SE};
  localparam logic [7:0]  DA = {2'd3, 2'd2, 2'd1, 2'd0};
  localparam int NV = 14;

  typedef struct {
    logic [31:0]      addr;
    logic             wr;
    logic [3:0][18:0] tags;
    logic [3:0]       vals;
    logic [3:0][2:0]  sts;
    logic [3:0][1:0]  ages;
    logic [1:0]       kind;
    logic [1:0]       way;
    logic [2:0]       st;
    logic [18:0]      vtag;
    logic             dirty;
    logic [3:0][2:0]  wst;
    logic [3:0][1:0]  wage;
  } vec_t;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [6:0]  tag_rd_set, tag_wr_set;
  logic [75:0] tag_rd_tags;
  logic [3:0]  tag_rd_valids;
  logic [11:0] tag_rd_states;
  logic [7:0]  tag_rd_lru;
  logic        tag_wr_en, tag_wr_valid;
  logic [1:0]  tag_wr_way, tag_wr_lru;
  logic [18:0] tag_wr_tag, resp_victim_tag;
  logic [2:0]  tag_wr_state, resp_state;
  logic        resp_valid, resp_ready, resp_victim_dirty;
  logic [1:0]  resp_kind, resp_way;

  cache_lookup_ctrl #(.SETS(128), .WAYS(4), .ADDR_WIDTH(32), .LRU_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .tag_rd_set(tag_rd_set), .tag_rd_tags(tag_rd_tags), .tag_rd_valids(tag_rd_valids),
    .tag_rd_states(tag_rd_states), .tag_rd_lru(tag_rd_lru),
    .tag_wr_en(tag_wr_en), .tag_wr_set(tag_wr_set), .tag_wr_way(tag_wr_way), .tag_wr_tag(tag_wr_tag),
    .tag_wr_valid(tag_wr_valid), .tag_wr_state(tag_wr_state), .tag_wr_lru(tag_wr_lru),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_kind(resp_kind), .resp_way(resp_way),
    .resp_state(resp_state), .resp_victim_tag(resp_victim_tag), .resp_victim_dirty(resp_victim_dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag array model: only set 1 is exercised, so one set of storage is kept.
  logic [18:0] m_tag [4];
  logic        m_val [4];
  logic [2:0]  m_st  [4];
  logic [1:0]  m_lru [4];
  vec_t        pl;
  logic        pl_go;

  always @(posedge clk) begin
    if (pl_go) begin
      for (int w = 0; w < 4; w++) begin
        m_tag[w] <= pl.tags[w];
        m_val[w] <= pl.vals[w];
        m_st[w]  <= pl.sts[w];
        m_lru[w] <= pl.ages[w];
      end
    end else if (tag_wr_en && tag_wr_set == 7'd1) begin
      m_tag[tag_wr_way] <= tag_wr_tag;
      m_val[tag_wr_way] <= tag_wr_valid;
      m_st[tag_wr_way]  <= tag_wr_state;
      m_lru[tag_wr_way] <= tag_wr_lru;
    end
  end

  always_comb begin
    tag_rd_tags = '0; tag_rd_valids = '0; tag_rd_states = '0; tag_rd_lru = '0;
    for (int w = 0; w < 4; w++) begin
      tag_rd_tags[w*19 +: 19] = m_tag[w];
      tag_rd_valids[w]        = m_val[w];
      tag_rd_states[w*3 +: 3] = m_st[w];
      tag_rd_lru[w*2 +: 2]    = m_lru[w];
    end
  end

  int   total = 0;
  int   bad = 0;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [75:0] t,
                              input logic [3:0] vl, input logic [11:0] s, input logic [7:0] ag,
                              input logic [1:0] kd, input logic [1:0] wy, input logic [2:0] st,
                              input logic [18:0] vt, input logic d, input logic [11:0] ws,
                              input logic [7:0] wa);
    vec_t v;
    v.addr = a; v.wr = w; v.tags = t; v.vals = vl; v.sts = s; v.ages = ag;
    v.kind = kd; v.way = wy; v.st = st; v.vtag = vt; v.dirty = d; v.wst = ws; v.wage = wa;
    return v;
  endfunction

  task automatic preload(input vec_t v);
    @(negedge clk);
    pl = v; pl_go = 1'b1;
    @(negedge clk);
    pl_go = 1'b0;
  endtask

  task automatic accept(input logic [31:0] a, input logic w, input string nm);
    req_addr = a; req_write = w; req_valid = 1'b1;
    chk({nm, " req_ready idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    int    rvk, nwr;
    logic  hit;
    nm  = $sformatf("v%0d", idx);
    hit = (v.kind != 2'b01);
    preload(v);
    accept(v.addr, v.wr, nm);
    rvk = 0; nwr = 0;
    for (int k = 1; k <= 12 && rvk == 0; k++) begin
      @(negedge clk);
      if (k == 1)
        chk({nm, " lookup rdy/rv/wr"}, 32'({req_ready, resp_valid, tag_wr_en}), 32'd0);
      if (tag_wr_en) begin
        nwr++;
        chk({nm, " wr way"}, 32'(tag_wr_way), 32'(k - 2));
        chk({nm, " wr set"}, 32'(tag_wr_set), 32'd1);
        chk({nm, " wr tag"}, 32'(tag_wr_tag), 32'(v.tags[tag_wr_way]));
        chk({nm, " wr valid"}, 32'(tag_wr_valid), 32'(v.vals[tag_wr_way]));
        chk({nm, " wr state"}, 32'(tag_wr_state), 32'(v.wst[tag_wr_way]));
        chk({nm, " wr lru"}, 32'(tag_wr_lru), 32'(v.wage[tag_wr_way]));
      end
      if (resp_valid) begin
        rvk = k;
        chk({nm, " kind"}, 32'(resp_kind), 32'(v.kind));
        chk({nm, " way"}, 32'(resp_way), 32'(v.way));
        chk({nm, " state"}, 32'(resp_state), 32'(v.st));
        if (!hit) chk({nm, " victim tag"}, 32'(resp_victim_tag), 32'(v.vtag));
        chk({nm, " dirty"}, 32'(resp_victim_dirty), 32'(v.dirty));
        chk({nm, " rdy in resp"}, 32'(req_ready), 32'd0);
      end
    end
    chk({nm, " resp cycle"}, 32'(rvk), hit ? 32'd6 : 32'd2);
    chk({nm, " write count"}, 32'(nwr), hit ? 32'd4 : 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({nm, " back to idle"}, 32'({req_ready, resp_valid}), 32'b10);
  endtask

  task automatic wait_resp(output int kk);
    kk = 0;
    for (int k = 1; k <= 12 && kk == 0; k++) begin
      @(negedge clk);
      if (resp_valid) kk = k;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int kk;
    tbl[0]  = mk(32'h0000_2040, 0, '0, 4'h0, '0, '0, 2'b01, 2'd0, SI, 19'd0, 0, '0, '0);
    tbl[1]  = mk(32'h0000_E040, 0, DT, 4'hF, DS, DA, 2'b00, 2'd2, SM, 19'd7, 0, DS,
                 {2'd3, 2'd0, 2'd2, 2'd1});
    tbl[2]  = mk(32'h0000_A040, 1, DT, 4'hF, DS, DA, 2'b00, 2'd0, SE, 19'd5, 0,
                 {SO, SM, SS, SM}, {2'd3, 2'd2, 2'd1, 2'd0});
    tbl[3]  = mk(32'h0000_C040, 1, DT, 4'hF, DS, DA, 2'b10, 2'd1, SS, 19'd6, 0, DS,
                 {2'd3, 2'd2, 2'd0, 2'd1});
    tbl[4]  = mk(32'h0001_2040, 0, DT, 4'hF, DS, DA, 2'b01, 2'd3, SO, 19'd8, 1, '0, '0);
    tbl[5]  = mk(32'h0001_2040, 0, DT, 4'hF, {SO, SM, SI, SE}, DA, 2'b01, 2'd1, SI, 19'd6, 0, '0, '0);
    tbl[6]  = mk(32'h0001_0040, 0, DT, 4'hF, DS, DA, 2'b00, 2'd3, SO, 19'd8, 0, DS,
                 {2'd0, 2'd3, 2'd2, 2'd1});
    tbl[7]  = mk(32'h0001_0040, 1, DT, 4'hF, DS, DA, 2'b10, 2'd3, SO, 19'd8, 0, DS,
                 {2'd0, 2'd3, 2'd2, 2'd1});
    tbl[8]  = mk(32'h0000_E040, 1, DT, 4'hF, DS, DA, 2'b00, 2'd2, SM, 19'd7, 0, DS,
                 {2'd3, 2'd0, 2'd2, 2'd1});
    tbl[9]  = mk(32'h0001_2040, 0, DT, 4'hF, {SE, SE, SE, SE}, {2'd1, 2'd3, 2'd3, 2'd2},
                 2'b01, 2'd1, SE, 19'd6, 0, '0, '0);
    tbl[10] = mk(32'h0000_A040, 0, DT, 4'hF, DS, 8'hFF, 2'b00, 2'd0, SE, 19'd5, 0, DS,
                 {2'd3, 2'd3, 2'd3, 2'd0});
    tbl[11] = mk(32'h0000_E040, 0, {19'd8, 19'd7, 19'd7, 19'd5}, 4'hF, DS, DA, 2'b00, 2'd1, SS,
                 19'd7, 0, DS, {2'd3, 2'd2, 2'd0, 2'd1});
    tbl[12] = mk(32'h0000_E040, 0, {19'd8, 19'd7, 19'd6, 19'd7}, 4'hE, DS, DA, 2'b00, 2'd2, SM,
                 19'd7, 0, DS, {2'd3, 2'd0, 2'd2, 2'd1});
    tbl[13] = mk(32'h0001_2040, 0, DT, 4'hF, {SM, SM, SS, SE}, DA, 2'b01, 2'd3, SM, 19'd8, 1, '0, '0);

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; resp_ready = 1'b0;
    pl = tbl[0]; pl_go = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready/rv/wr", 32'({req_ready, resp_valid, tag_wr_en}), 32'b100);
    chk("reset resp fields", 32'({resp_kind, resp_way, resp_state, resp_victim_dirty, tag_rd_set}), 32'd0);
    chk("reset victim tag", 32'(resp_victim_tag), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, tbl[i]);

    // Response held under back-pressure, then a request presented on the release cycle.
    preload(tbl[4]);
    accept(32'h0001_2040, 1'b0, "hold");
    wait_resp(kk);
    chk("hold resp cycle", 32'(kk), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold c%0d fields", c),
          32'({resp_valid, req_ready, resp_kind, resp_way, resp_state, resp_victim_tag, resp_victim_dirty}),
          32'({1'b1, 1'b0, 2'b01, 2'd3, SO, 19'd8, 1'b1}));
    end
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_E040; req_write = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("release idle not taken", 32'({req_ready, resp_valid}), 32'b10);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("release accepted next", 32'(req_ready), 32'd0);
    wait_resp(kk);
    chk("release resp cycle", 32'(kk), 32'd6);
    chk("release resp way/kind", 32'({resp_way, resp_kind}), 32'({2'd2, 2'b00}));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Reset asserted during the second update cycle.
    preload(tbl[1]);
    accept(32'h0000_E040, 1'b0, "rst");
    repeat (3) @(negedge clk);
    chk("rst pre wr way1", 32'({tag_wr_en, tag_wr_way}), 32'({1'b1, 2'd1}));
    #2 rst_n = 1'b0;
    #1;
    chk("rst async ready/rv/wr", 32'({req_ready, resp_valid, tag_wr_en}), 32'b100);
    chk("rst async fields", 32'({resp_kind, resp_way, resp_state, tag_rd_set}), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst hold c%0d wr", c), 32'(tag_wr_en), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst after c%0d", c), 32'({req_ready, resp_valid, tag_wr_en}), 32'b100);
    end
    chk("rst way0 written", 32'(m_lru[0]), 32'd1);
    chk("rst way1 untouched", 32'(m_lru[1]), 32'd1);
    chk("rst way2 untouched", 32'({m_lru[2], m_st[2]}), 32'({2'd2, SM}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
